// File: rtl/reaction_test_ctrl.sv
// Reaction-time test sequencer: random pre-stimulus delay, stimulus LED,
// millisecond reaction measurement with too-early and timeout detection.
module reaction_test_ctrl #(
  parameter int unsigned CLK_PER_MS   = 100000,
  parameter int unsigned WAIT_MIN_MS  = 1000,
  parameter int unsigned RAND_BITS    = 10,
  parameter int unsigned MAX_REACT_MS = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        btn,
  input  logic        abort,
  output logic        led_on,
  output logic        busy,
  output logic        result_valid,
  output logic        too_early,
  output logic        timeout,
  output logic [13:0] react_ms
);

  localparam int unsigned MS_W    = 14;
  localparam int unsigned LFSR_W  = 16;
  localparam int unsigned PRESC_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_PER_MS - 1);
  localparam logic [MS_W-1:0]    MAX_MS     = MS_W'(MAX_REACT_MS);
  localparam logic [MS_W-1:0]    WAIT_MIN   = MS_W'(WAIT_MIN_MS);
  localparam logic [LFSR_W-1:0]  LFSR_SEED  = 16'hACE1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_STIM,
    S_DONE,
    S_EARLY,
    S_TMO
  } state_t;

  state_t              state_q, state_nxt;
  logic [PRESC_W-1:0]  presc_q, presc_nxt;
  logic [MS_W-1:0]     delay_q, delay_nxt;
  logic [MS_W-1:0]     react_q, react_nxt;
  logic [MS_W-1:0]     react_ms_nxt;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_nxt;
  logic                tick;

  // One-cycle millisecond strobe from the prescaler
  assign tick = (presc_q == PRESC_LAST);

  // Fibonacci LFSR, taps 16/14/13/11, shifting right every cycle
  assign lfsr_nxt = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[LFSR_W-1:1]};

  // Next-state and datapath decode; abort > btn > tick > start
  always_comb begin
    state_nxt    = state_q;
    presc_nxt    = tick ? '0 : presc_q + PRESC_W'(1);
    delay_nxt    = delay_q;
    react_nxt    = react_q;
    react_ms_nxt = react_ms;

    if (abort) begin
      state_nxt    = S_IDLE;
      react_ms_nxt = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_EARLY, S_TMO: begin
          if (start) begin
            state_nxt    = S_ARM;
            delay_nxt    = WAIT_MIN + MS_W'(lfsr_q[RAND_BITS-1:0]);
            presc_nxt    = '0;
            react_ms_nxt = '0;
          end
        end
        S_ARM: begin
          if (btn) begin
            state_nxt    = S_EARLY;
            react_ms_nxt = '0;
          end else if (tick) begin
            delay_nxt = delay_q - MS_W'(1);
            // A zero count is treated as already expired so it cannot wrap
            if (delay_q <= MS_W'(1)) begin
              state_nxt = S_STIM;
              react_nxt = '0;
              presc_nxt = '0;
            end
          end
        end
        S_STIM: begin
          if (btn) begin
            state_nxt    = S_DONE;
            react_ms_nxt = (react_q > MAX_MS) ? MAX_MS : react_q;
          end else if (tick) begin
            if (react_q >= MAX_MS - MS_W'(1)) begin
              state_nxt    = S_TMO;
              react_ms_nxt = MAX_MS;
            end else begin
              react_nxt = react_q + MS_W'(1);
            end
          end
        end
        default: begin
          state_nxt    = S_IDLE;
          react_ms_nxt = '0;
        end
      endcase
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      presc_q      <= '0;
      delay_q      <= '0;
      react_q      <= '0;
      lfsr_q       <= LFSR_SEED;
      led_on       <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      too_early    <= 1'b0;
      timeout      <= 1'b0;
      react_ms     <= '0;
    end else begin
      state_q      <= state_nxt;
      presc_q      <= presc_nxt;
      delay_q      <= delay_nxt;
      react_q      <= react_nxt;
      lfsr_q       <= lfsr_nxt;
      led_on       <= (state_nxt == S_STIM);
      busy         <= (state_nxt == S_ARM) || (state_nxt == S_STIM);
      result_valid <= (state_nxt == S_DONE) || (state_nxt == S_EARLY) || (state_nxt == S_TMO);
      too_early    <= (state_nxt == S_EARLY);
      timeout      <= (state_nxt == S_TMO);
      react_ms     <= react_ms_nxt;
    end
  end

endmodule

// File: tb/tb_reaction_test_ctrl.sv
// Scoreboard bench for reaction_test_ctrl: trials are scored from timing
// arithmetic, results are checked by a monitor when result_valid rises.
module tb_reaction_test_ctrl;

  localparam int CPM       = 4;
  localparam int WAIT_MIN  = 3;
  localparam int RAND_BITS = 2;
  localparam int MAX_MS    = 20;

  localparam int K_DONE  = 0;
  localparam int K_EARLY = 1;
  localparam int K_TMO   = 2;
  localparam int K_ABORT = 3;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        btn   = 1'b0;
  logic        abort = 1'b0;
  logic        led_on, busy, result_valid, too_early, timeout;
  logic [13:0] react_ms;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [15:0] m_lfsr;
  logic        rv_prev = 1'b0;

  typedef struct {
    int kind;
    int react;
    int at_cyc;
  } exp_t;
  exp_t exp_q[$];

  reaction_test_ctrl #(
    .CLK_PER_MS  (CPM),
    .WAIT_MIN_MS (WAIT_MIN),
    .RAND_BITS   (RAND_BITS),
    .MAX_REACT_MS(MAX_MS)
  ) dut (
    .clk         (clk),
    .rst         (rst_n),
    .start       (start),
    .btn         (btn),
    .abort       (abort),
    .led_on      (led_on),
    .busy        (busy),
    .result_valid(result_valid),
    .too_early   (too_early),
    .timeout     (timeout),
    .react_ms    (react_ms)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference LFSR sequence: seed ACE1, one step per clock since reset
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= lfsr_step(m_lfsr);
  end

  function automatic void check(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, expv, $time);
    end
  endfunction

  // Monitor: score each newly presented result against the queue head
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && result_valid && !rv_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("res_too_early", int'(too_early), int'(e.kind == K_EARLY));
        check("res_timeout",   int'(timeout),   int'(e.kind == K_TMO));
        check("res_react_ms",  int'(react_ms),  e.react);
        check("res_latency",   cyc,             e.at_cyc);
        check("res_led_off",   int'(led_on),    0);
        check("res_not_busy",  int'(busy),      0);
      end
    end
    rv_prev = rst_n && result_valid;
  end

  task automatic check_idle(input string tag);
    check({tag, "_led"},   int'(led_on),       0);
    check({tag, "_busy"},  int'(busy),         0);
    check({tag, "_rv"},    int'(result_valid), 0);
    check({tag, "_early"}, int'(too_early),    0);
    check({tag, "_tmo"},   int'(timeout),      0);
    check({tag, "_react"}, int'(react_ms),     0);
  endtask

  // One trial, called at a negedge. kb/ka/ks: edge index after the start
  // edge at which btn/abort/start is sampled (0 = never).
  task automatic run_trial(input int kb, input int ka, input int ks, input int hold);
    int d, arm, tmo, r, kind, react;
    d   = WAIT_MIN + int'(m_lfsr[RAND_BITS-1:0]);
    arm = CPM * d;
    tmo = arm + CPM * MAX_MS;
    if (ka != 0 && (kb == 0 || ka <= kb) && ka <= tmo) begin
      kind = K_ABORT; r = ka; react = 0;
    end else if (kb != 0 && kb <= tmo) begin
      r = kb;
      if (kb <= arm) begin kind = K_EARLY; react = 0; end
      else begin kind = K_DONE; react = (kb - arm - 1) / CPM; end
    end else begin
      kind = K_TMO; r = tmo; react = MAX_MS;
    end
    if (kind != K_ABORT) exp_q.push_back('{kind, react, cyc + 1 + r});

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy",  int'(busy),         1);
    check("start_led",   int'(led_on),       0);
    check("start_rv",    int'(result_valid), 0);
    check("start_early", int'(too_early),    0);
    check("start_tmo",   int'(timeout),      0);
    check("start_react", int'(react_ms),     0);

    for (int c = 1; c <= r; c++) begin
      btn   = (c == kb);
      abort = (c == ka);
      start = (c == ks);
      @(negedge clk);
      btn = 1'b0; abort = 1'b0; start = 1'b0;
      if (c < r) begin
        check("run_led",  int'(led_on),       int'(c >= arm));
        check("run_busy", int'(busy),         1);
        check("run_rv",   int'(result_valid), 0);
      end
    end

    if (kind == K_ABORT) check_idle("abort");
    #1;
    check("result_missing", exp_q.size(), 0);

    // btn after the result is ignored and the result is held
    for (int h = 0; h < hold; h++) begin
      btn = 1'b1;
      @(negedge clk);
      btn = 1'b0;
      check("hold_rv",    int'(result_valid), int'(kind != K_ABORT));
      check("hold_react", int'(react_ms),     react);
      check("hold_early", int'(too_early),    int'(kind == K_EARLY));
      check("hold_led",   int'(led_on),       0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, kb, ka, ks, mode;
    repeat (3) @(negedge clk);
    check_idle("reset");

    // Start on the first cycle after release: delay 4 ms, btn 29 clk after LED
    rst_n = 1'b1;
    run_trial(CPM * 4 + 29, 0, 0, 2);
    // btn during ARM
    run_trial(5, 0, 0, 1);
    // No btn: timeout
    run_trial(0, 0, 0, 1);
    // abort in STIM at the third tick, then a fresh test
    d = WAIT_MIN + int'(m_lfsr[RAND_BITS-1:0]);
    run_trial(0, CPM * d + 3 * CPM, 0, 2);
    d = WAIT_MIN + int'(m_lfsr[RAND_BITS-1:0]);
    run_trial(CPM * d + 10, 0, 3, 1);
    // start directly from DONE with a busy-time start pulse
    d = WAIT_MIN + int'(m_lfsr[RAND_BITS-1:0]);
    run_trial(CPM * d + 1 + CPM, 0, CPM * d + 2, 1);

    for (int t = 0; t < 24; t++) begin
      d    = WAIT_MIN + int'(m_lfsr[RAND_BITS-1:0]);
      mode = int'($urandom_range(0, 9));
      if (mode < 2)      kb = 0;
      else if (mode < 4) kb = int'($urandom_range(1, CPM * d));
      else               kb = int'($urandom_range(CPM * d + 1, CPM * d + CPM * MAX_MS + 2));
      ka = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, CPM * d + CPM * MAX_MS)) : 0;
      ks = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, CPM * d)) : 0;
      run_trial(kb, ka, ks, int'($urandom_range(1, 3)));
    end

    // Async reset in the middle of STIM drops the LED without a clock edge
    d = WAIT_MIN + int'(m_lfsr[RAND_BITS-1:0]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (CPM * d + 6) @(negedge clk);
    check("pre_rst_led", int'(led_on), 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_led",  int'(led_on), 0);
    check("async_rst_busy", int'(busy),   0);
    @(negedge clk);
    check_idle("mid_reset");
    rst_n = 1'b1;
    // After reset the LFSR is back at its seed, so the delay is 4 ms again
    run_trial(CPM * 4 + 9, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reaction_test_ctrl.md
Name: reaction_test_ctrl

Overview:
Sequences one reaction-time test for the health monitor:
- waits a pseudo-random delay;
- lights the stimulus LED;
- measures button reaction time in milliseconds.

It contains its own ms prescaler, delay countdown and reaction counter. It reports a latched result, a too-early fault or a timeout to the display/scoring logic.

Parameters:
- CLK_PER_MS, 100000: clk cycles per 1 ms tick (100 MHz clk).
- WAIT_MIN_MS, 1000: minimum pre-stimulus delay in ms.
- RAND_BITS, 10: LFSR bits added to the delay (0..2^RAND_BITS-1 ms extra).
- MAX_REACT_MS, 2000: reaction timeout in ms; must be < 16384.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous active-low reset.
- start, input, 1: 1-cycle pulse; begins a test.
- btn, input, 1: 1-cycle debounced button press pulse.
- abort, input, 1: level; forces return to IDLE.
- led_on, output, 1: stimulus LED.
- busy, output, 1: high in ARM or STIM.
- result_valid, output, 1: high while a DONE, EARLY or TMO result is held.
- too_early, output, 1: btn was pressed during ARM.
- timeout, output, 1: no btn within MAX_REACT_MS.
- react_ms, output, 14: measured reaction time in ms.

Behaviour:
- Reset (rst=0, async): state=IDLE, all outputs 0, prescaler/counters 0, LFSR=16'hACE1.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11; shifts every clk, never all-zero.
  - On accepted start, delay_cnt <= WAIT_MIN_MS + lfsr[RAND_BITS-1:0] (14-bit, zero-extended).
- Prescaler:
  - Counts 0..CLK_PER_MS-1; tick=1 for the cycle it equals CLK_PER_MS-1, then wraps to 0.
  - Cleared to 0 on entry to ARM and to STIM, so the first tick comes exactly CLK_PER_MS cycles after entry.
- States:
  - IDLE: outputs 0. start -> ARM. btn ignored.
  - ARM: busy=1.
    - On tick, delay_cnt decrements.
    - On the tick where delay_cnt==1 -> STIM, react_cnt<=0.
    - btn -> EARLY.
  - STIM: busy=1, led_on=1.
    - On tick, react_cnt increments.
    - btn -> DONE, react_ms<=react_cnt.
    - Tick with react_cnt==MAX_REACT_MS-1 -> TMO, react_ms<=MAX_REACT_MS.
  - DONE: result_valid=1, react_ms held.
  - EARLY: result_valid=1, too_early=1, react_ms=0.
  - TMO: result_valid=1, timeout=1.
  - DONE/EARLY/TMO: start -> ARM, clearing too_early, timeout, result_valid and react_ms on the same edge.
- Latency:
  - State outputs are registered.
  - result_valid, too_early and timeout rise on the clk edge after the sampled btn or final tick.
  - led_on rises on the edge where the final ARM tick is sampled.
- Priority and simultaneous events:
  - abort > btn > tick > start.
  - abort (any state) -> IDLE next edge; all outputs cleared; held result discarded.
  - btn and final tick together in ARM -> EARLY (LED never lights).
  - btn and tick together in STIM -> DONE with the pre-increment react_cnt.
  - btn and timeout tick together -> DONE.
  - start while busy is ignored; no restart.
  - btn in DONE/EARLY/TMO is ignored.
- react_ms saturates at MAX_REACT_MS and never wraps.
- rst asserted mid-test: immediate IDLE, LED off.

Test Plan:
Bench parameters: CLK_PER_MS=4, WAIT_MIN_MS=3, RAND_BITS=2, MAX_REACT_MS=20.
1. Reset then start on the first cycle after release (lfsr[1:0]=01 from seed ACE1) -> delay 4 ms; led_on rises 16 clk after ARM entry; busy=1 throughout.
2. btn issued 29 clk after led_on rises (7 ticks elapsed) -> next edge: result_valid=1, react_ms=7, led_on=0, busy=0; held until the next start.
3. btn during ARM, 5 clk after start -> EARLY: too_early=1, result_valid=1, react_ms=0; led_on never asserts.
4. No btn after stimulus -> after 80 clk: timeout=1, react_ms=20, led_on=0.
5. abort asserted in STIM at tick 3 -> IDLE next edge, all outputs 0; a subsequent start runs a fresh test.
6. start pulsed while busy -> ignored, delay unchanged. start from DONE -> flags clear on the same edge and a new ARM begins. Async rst pulse mid-STIM -> led_on=0 without a clock edge.
